snax_csr_responder: RTL
=======================

SNAX_CSR_RESPONDER -- requirements
Module: snax_csr_responder

Interface
REQ-001 Parameters SHALL be: NumRwCsr, default 4, the number of read/write CSRs, where index NumRwCsr-1 is the launch CSR.
REQ-002 Parameter NumRoCsr SHALL default to 2 and give the number of read-only CSRs, where the last one is the internal busy-cycle counter.
REQ-003 Parameter CsrAddrOffset SHALL default to 960 and give the CSR address mapped to RW index 0.
REQ-004 Ports SHALL be:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
REQ-005 Request ports SHALL be:
- req_addr_i  in  32  CSR address (data_argb)
- req_data_i  in  32  write data (data_arga)
- req_write_i  in  1  1=csrw, 0=csrr
- req_id_i  in  5  register id
- req_qvalid_i  in  1  request valid
- req_qready_o  out  1  request ready
REQ-006 Response ports SHALL be:
- rsp_data_o  out  32  read data
- rsp_id_o  out  5  echoed id
- rsp_error_o  out  1  unmapped address
- rsp_pvalid_o  out  1  response valid
- rsp_pready_i  in  1  response ready
REQ-007 Accelerator-side ports SHALL be:
- acc_csr_o  out  32*(NumRwCsr-1)  configuration registers
- acc_launch_valid_o  out  1  launch request
- acc_launch_ready_i  in  1  launch accepted
- acc_busy_i  in  1  accelerator busy
- acc_ro_csr_i  in  32*(NumRoCsr-1)  status registers

Function
REQ-008 The CSR index SHALL be idx = req_addr_i - CsrAddrOffset, a 32-bit unsigned wrap, so addresses below the offset are unmapped.
REQ-009 The mapping SHALL be: idx<NumRwCsr is RW; NumRwCsr<=idx<NumRwCsr+NumRoCsr is RO; otherwise unmapped.
REQ-010 A request SHALL transfer on a cycle with req_qvalid_i & req_qready_o.
REQ-011 RW write, idx<NumRwCsr-1: the shadow register SHALL update on the transfer edge; no response is generated.
REQ-012 Launch write, idx=NumRwCsr-1, data[0]=1: the launch register SHALL store data, and acc_launch_valid_o SHALL rise on the following cycle and hold until the acc_launch_ready_i handshake.
- A launch write with data[0]=0 SHALL store data only.
REQ-013 While acc_launch_valid_o & ~acc_launch_ready_i, req_qready_o SHALL be 0 for every write, so acc_csr_o stays stable during launch.
REQ-014 acc_csr_o SHALL be driven directly from shadow registers 0..NumRwCsr-2.
REQ-015 Writes to RO or unmapped indices SHALL be dropped silently, with no state change and no response.
REQ-016 A read SHALL produce exactly one response, with rsp_pvalid_o high on the cycle after transfer and rsp_id_o=req_id_i.
REQ-017 Read data SHALL be:
- RW: shadow value.
- RO index k<NumRoCsr-1: acc_ro_csr_i slice k, sampled at transfer.
- Last RO: busy counter.
- Unmapped: 0 with rsp_error_o=1.
- rsp_error_o SHALL be 0 in all other cases.
REQ-018 The response path SHALL be a one-entry buffer, held while rsp_pvalid_o & ~rsp_pready_i.
REQ-019 For reads, req_qready_o SHALL be ~rsp_pvalid_o | rsp_pready_i, allowing back-to-back reads at full throughput when pready is held at 1.
REQ-020 For writes, req_qready_o SHALL be 1 except in the REQ-013 case; writes SHALL be accepted while a read response is pending.
REQ-021 The busy counter SHALL be 32 bits, increment each cycle acc_busy_i=1, and saturate at 0xFFFFFFFF.
- It SHALL clear to 0 on the launch handshake cycle; the clear takes priority over increment.
REQ-022 Reading the launch CSR SHALL return its stored value, where bit0 reads 1 while acc_launch_valid_o is high and 0 otherwise.
REQ-023 All outputs SHALL be registered, except req_qready_o, which is combinational from state, req_write_i, req_qvalid_i and rsp_pready_i.

Reset
REQ-024 While rst_i=1 at a clk_i edge, all shadow, launch and counter registers SHALL reset to 0.
REQ-025 Reset SHALL clear acc_launch_valid_o, rsp_pvalid_o, rsp_data_o, rsp_id_o and rsp_error_o to 0.
REQ-026 Reset asserted mid-launch or with a pending response SHALL drop that launch or response without a handshake.
REQ-027 req_qready_o SHALL be 0 while rst_i=1.

Verification
REQ-028 The bench SHALL cover: write 0xDEADBEEF to addr 960, then read 960 with id 3 -> acc_csr_o[31:0]=0xDEADBEEF; next-cycle response data=0xDEADBEEF, id=3, error=0.
REQ-029 The bench SHALL cover: write 1 to addr 963, acc_launch_ready_i=0 for 4 cycles -> launch_valid high from the next cycle for 5 cycles; a write to 960 during that window sees qready=0; a read to 960 during that window is accepted.
REQ-030 The bench SHALL cover: launch handshake, then acc_busy_i=1 for 10 cycles, then read addr 965 -> data=10; a second launch handshake, then read -> data=0.
REQ-031 The bench SHALL cover: read addr 959 and read addr 1000 -> both respond data=0, error=1; a write to 964 leaves all state unchanged with no response.
REQ-032 The bench SHALL cover: two back-to-back reads with rsp_pready_i=0 for 3 cycles -> first response held stable, second request stalled with qready=0 until pready=1, responses delivered in order.
REQ-033 The bench SHALL cover: assert rst_i while launch_valid=1 and a response is pending -> on the next cycle all outputs are 0, and a subsequent read of 960 returns 0.

Source files
------------

// File: rtl/snax_csr_responder_if.sv
// CSR request/response channel between a SNAX core (master) and the
// accelerator-side CSR responder (slave).
interface snax_csr_responder_if;
  logic [31:0] req_addr_i;
  logic [31:0] req_data_i;
  logic        req_write_i;
  logic [4:0]  req_id_i;
  logic        req_qvalid_i;
  logic        req_qready_o;

  logic [31:0] rsp_data_o;
  logic [4:0]  rsp_id_o;
  logic        rsp_error_o;
  logic        rsp_pvalid_o;
  logic        rsp_pready_i;

  modport slave (
    input  req_addr_i, req_data_i, req_write_i, req_id_i, req_qvalid_i,
    input  rsp_pready_i,
    output req_qready_o,
    output rsp_data_o, rsp_id_o, rsp_error_o, rsp_pvalid_o
  );

  modport master (
    output req_addr_i, req_data_i, req_write_i, req_id_i, req_qvalid_i,
    output rsp_pready_i,
    input  req_qready_o,
    input  rsp_data_o, rsp_id_o, rsp_error_o, rsp_pvalid_o
  );
endinterface

// File: rtl/snax_csr_responder.sv
// CSR responder: RW shadow registers with a launch CSR, RO status registers
// with a busy-cycle counter, and a one-entry read response buffer.
module snax_csr_responder #(
  parameter int unsigned NumRwCsr      = 4,
  parameter int unsigned NumRoCsr      = 2,
  parameter int unsigned CsrAddrOffset = 960
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  snax_csr_responder_if.slave         csr,
  output logic [32*(NumRwCsr-1)-1:0]  acc_csr_o,
  output logic                        acc_launch_valid_o,
  input  logic                        acc_launch_ready_i,
  input  logic                        acc_busy_i,
  input  logic [32*(NumRoCsr-1)-1:0]  acc_ro_csr_i
);

  localparam int unsigned LaunchIdx = NumRwCsr - 1;
  localparam int unsigned BusyIdx   = NumRwCsr + NumRoCsr - 1;

  logic [31:0] shadow_q [NumRwCsr];
  logic [31:0] shadow_d [NumRwCsr];
  logic        launch_valid_q, launch_valid_d;
  logic [31:0] busy_cnt_q, busy_cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [4:0]  rsp_id_q, rsp_id_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] idx;
  logic        is_rw, is_ro;
  logic        launch_hs, launch_stall;
  logic        qready, wr_fire, rd_fire;
  logic [31:0] rd_data;
  logic        rd_err;

  // Address decode: the subtraction wraps, so addresses below the offset land
  // far above the mapped range.
  assign idx   = csr.req_addr_i - 32'(CsrAddrOffset);
  assign is_rw = idx < 32'(NumRwCsr);
  assign is_ro = !is_rw && (idx < 32'(NumRwCsr + NumRoCsr));

  assign launch_hs    = launch_valid_q & acc_launch_ready_i;
  // Configuration must not move under the accelerator while a launch is pending.
  assign launch_stall = launch_valid_q & ~acc_launch_ready_i;

  always_comb begin
    qready = 1'b0;
    if (!rst_i) begin
      if (csr.req_write_i) qready = ~launch_stall;
      else                 qready = ~rsp_valid_q | csr.rsp_pready_i;
    end
  end

  assign wr_fire = csr.req_qvalid_i & qready & csr.req_write_i;
  assign rd_fire = csr.req_qvalid_i & qready & ~csr.req_write_i;

  // Read data mux
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (is_rw) begin
      for (int unsigned i = 0; i < NumRwCsr; i++) begin
        if (idx == 32'(i)) begin
          rd_data = shadow_q[i];
          if (i == LaunchIdx) rd_data[0] = launch_valid_q;
        end
      end
    end else if (is_ro) begin
      for (int unsigned k = 0; k < NumRoCsr - 1; k++) begin
        if (idx == 32'(NumRwCsr + k)) rd_data = acc_ro_csr_i[32*k +: 32];
      end
      if (idx == 32'(BusyIdx)) rd_data = busy_cnt_q;
    end else begin
      rd_err = 1'b1;
    end
  end

  // Next-state: shadows, launch flag, busy counter, response buffer
  always_comb begin
    for (int unsigned i = 0; i < NumRwCsr; i++) shadow_d[i] = shadow_q[i];
    launch_valid_d = launch_valid_q & ~launch_hs;
    if (wr_fire && is_rw) begin
      for (int unsigned i = 0; i < NumRwCsr; i++) begin
        if (idx == 32'(i)) begin
          shadow_d[i] = csr.req_data_i;
          if (i == LaunchIdx && csr.req_data_i[0]) launch_valid_d = 1'b1;
        end
      end
    end

    busy_cnt_d = busy_cnt_q;
    if (launch_hs)                              busy_cnt_d = '0;
    else if (acc_busy_i && busy_cnt_q != '1)    busy_cnt_d = busy_cnt_q + 32'd1;

    rsp_valid_d = rsp_valid_q & ~csr.rsp_pready_i;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    if (rd_fire) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rd_data;
      rsp_id_d    = csr.req_id_i;
      rsp_err_d   = rd_err;
    end
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumRwCsr; i++) shadow_q[i] <= '0;
      launch_valid_q <= 1'b0;
      busy_cnt_q     <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_id_q       <= '0;
      rsp_err_q      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NumRwCsr; i++) shadow_q[i] <= shadow_d[i];
      launch_valid_q <= launch_valid_d;
      busy_cnt_q     <= busy_cnt_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_id_q       <= rsp_id_d;
      rsp_err_q      <= rsp_err_d;
    end
  end

  always_comb begin
    acc_csr_o = '0;
    for (int unsigned i = 0; i < NumRwCsr - 1; i++) acc_csr_o[32*i +: 32] = shadow_q[i];
  end

  assign acc_launch_valid_o = launch_valid_q;
  assign csr.req_qready_o   = qready;
  assign csr.rsp_pvalid_o   = rsp_valid_q;
  assign csr.rsp_data_o     = rsp_data_q;
  assign csr.rsp_id_o       = rsp_id_q;
  assign csr.rsp_error_o    = rsp_err_q;

endmodule
